// File: rtl/lvds_video_timing.sv
// Pixel-rate video timing and solid/colour-bar pattern source for the LVDS 7:1 serializer.
// Optional colour bars are compiled in with `define LVDS_COLORBAR_EN.
module lvds_video_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        ene,
  input  logic [23:0] color,
  input  logic        pattern_sel,
  output logic [23:0] pixel_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [23:0]     col_q, col_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fs_q, fs_d;

  logic            adv;
  logic            h_last;
  logic            v_last;
  logic            sof;
  logic            in_act;
  logic            in_hs;
  logic            in_vs;
  logic [23:0]     col_use;
  logic [23:0]     fill;

`ifdef LVDS_COLORBAR_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic            pat_q, pat_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [BPW-1:0]  bar_px_q, bar_px_d;
  logic            pat_use;
  logic [23:0]     bar_rgb;

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_idx_q)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
      default: bar_rgb = 24'h000000;
    endcase
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  assign adv    = pix_ce && (state_q != IDLE);
  assign h_last = int'(h_cnt_q) == H_TOTAL - 1;
  assign v_last = int'(v_cnt_q) == V_TOTAL - 1;
  assign sof    = adv && (h_cnt_q == '0) && (v_cnt_q == '0);

  assign in_act = (int'(h_cnt_q) < H_ACTIVE) &&
                  (int'(v_cnt_q) < V_ACTIVE);
  assign in_hs  = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                  (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
  assign in_vs  = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                  (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);

  // Pixel (0,0) must already use the colour being latched on its edge
  assign col_use = sof ? color : col_q;
`ifdef LVDS_COLORBAR_EN
  assign pat_use = sof ? pattern_sel : pat_q;
  assign fill    = pat_use ? bar_rgb : col_use;
`else
  assign fill    = col_use;
`endif

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    col_d   = col_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    fs_d    = 1'b0;
`ifdef LVDS_COLORBAR_EN
    pat_d     = pat_q;
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
`endif

    if (adv) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end
      rgb_d = in_act ? fill : 24'h0;
      de_d  = in_act;
      hs_d  = in_hs ? SYNC_POL : ~SYNC_POL;
      vs_d  = in_vs ? SYNC_POL : ~SYNC_POL;
      fs_d  = sof;
      if (sof) begin
        col_d = color;
      end
`ifdef LVDS_COLORBAR_EN
      if (sof) begin
        pat_d = pattern_sel;
      end
      if (h_last) begin
        bar_idx_d = 3'd0;
        bar_px_d  = '0;
      end else if (bar_idx_q != 3'd7) begin
        if (int'(bar_px_q) == BAR_W - 1) begin
          bar_idx_d = bar_idx_q + 3'd1;
          bar_px_d  = '0;
        end else begin
          bar_px_d  = bar_px_q + BPW'(1);
        end
      end
`endif
    end

    unique case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        rgb_d   = 24'h0;
        de_d    = 1'b0;
        hs_d    = ~SYNC_POL;
        vs_d    = ~SYNC_POL;
        if (ene) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!ene) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ene) begin
          state_d = RUN;
        end else if (adv && h_last && v_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      col_q   <= 24'h0;
      rgb_q   <= 24'h0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
`ifdef LVDS_COLORBAR_EN
      pat_q     <= 1'b0;
      bar_idx_q <= 3'd0;
      bar_px_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      col_q   <= col_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
`ifdef LVDS_COLORBAR_EN
      pat_q     <= pat_d;
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
`endif
    end
  end

  assign pixel_rgb   = rgb_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign busy        = state_q != IDLE;

endmodule

// File: tb/tb_lvds_video_timing.sv
// Bench for lvds_video_timing: frame-index model compared every cycle,
// plus hand-computed timing points.
module tb_lvds_video_timing;

  localparam int HA = 16, HF = 2, HS = 2, HB = 4;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FP = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b0;
  logic        ene = 1'b0;
  logic [23:0] color = 24'h0;
  logic        pattern_sel = 1'b0;
  logic [23:0] pixel_rgb;
  logic        de, hsync, vsync, frame_start, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ce_mode = 0;

  lvds_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_ce(pix_ce),
    .ene(ene),
    .color(color),
    .pattern_sel(pattern_sel),
    .pixel_rgb(pixel_rgb),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                            24'h00FF00, 24'hFF00FF, 24'hFF0000,
                            24'h0000FF, 24'h000000};

  function automatic logic [23:0] pix_color(int h, logic [23:0] c,
                                            logic p);
    int idx;
`ifdef LVDS_COLORBAR_EN
    if (p) begin
      idx = h / (HA / 8);
      if (idx > 7) idx = 7;
      return bars[idx];
    end
`endif
    idx = int'(p);
    return c;
  endfunction

  // Model: state 0 idle, 1 run, 2 drain; position is a linear pixel index
  int          m_state = 0;
  int          m_pix = 0;
  int          m_old;
  int          mh, mv;
  logic        m_wrap;
  logic [23:0] m_col = 0;
  logic        m_pat = 0;
  logic [23:0] e_rgb = 0;
  logic        e_de = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_busy = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_pix = 0; m_col = 0; m_pat = 0;
      e_rgb = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_busy = 0;
    end else begin
      m_old = m_state;
      m_wrap = 1'b0;
      e_fs = 1'b0;
      if (m_old == 0) begin
        e_rgb = 0; e_de = 0; e_hs = 0; e_vs = 0;
      end else if (pix_ce) begin
        if (m_pix == 0) begin
          m_col = color;
          m_pat = pattern_sel;
          e_fs = 1'b1;
        end
        mh = m_pix % HT;
        mv = m_pix / HT;
        e_de = (mh < HA) && (mv < VA);
        e_rgb = e_de ? pix_color(mh, m_col, m_pat) : 24'h0;
        e_hs = (mh >= HA + HF) && (mh < HA + HF + HS);
        e_vs = (mv >= VA + VF) && (mv < VA + VF + VS);
        m_wrap = (m_pix == FP - 1);
        m_pix = (m_pix + 1) % FP;
      end
      case (m_old)
        0: if (ene) m_state = 1;
        1: if (!ene) m_state = 2;
        default: begin
          if (ene) m_state = 1;
          else if (m_wrap) m_state = 0;
        end
      endcase
      e_busy = (m_state != 0);
    end
  end

  always @(negedge clk) begin
    tests++;
    if ({pixel_rgb, de, hsync, vsync, frame_start, busy} !==
        {e_rgb, e_de, e_hs, e_vs, e_fs, e_busy}) begin
      fails++;
      $display("FAIL model cyc=%0d got rgb=%h de=%b hs=%b vs=%b fs=%b busy=%b required rgb=%h de=%b hs=%b vs=%b fs=%b busy=%b",
               cyc, pixel_rgb, de, hsync, vsync, frame_start, busy,
               e_rgb, e_de, e_hs, e_vs, e_fs, e_busy);
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
      case (ce_mode)
        0: pix_ce = 1'b1;
        1: pix_ce = (cyc % 3 == 0);
        default: pix_ce = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic wait_fs(string name, int limit, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_start && n < limit);
    if (!frame_start) chk({name, "_timeout"}, 32'(n), 32'(limit + 1));
  endtask

  int n;

  initial begin
    step(3);
    chk("reset_rgb", 32'(pixel_rgb), 0);
    chk("reset_flags", {27'd0, de, hsync, vsync, frame_start, busy}, 0);

    rst = 1'b1; ene = 1'b1; color = 24'h123456;
    step(1);
    chk("start_busy", 32'(busy), 1);
    chk("start_de_wait", 32'(de), 0);
    step(1);
    chk("first_rgb", 32'(pixel_rgb), 32'h123456);
    chk("first_de_fs", {30'd0, de, frame_start}, 3);
    wait_fs("period", 400, n);
    chk("fs_period", 32'(n), FP);

    step(18);
    chk("hsync_18", {29'd0, hsync, de, 1'b0} | 32'(pixel_rgb != 0), 4);
    step(2);
    chk("hsync_20", 32'(hsync), 0);
    step(100);
    chk("vsync_line5", {30'd0, vsync, de}, 2);

    ce_mode = 1;
    step(700);
    ce_mode = 0;

    wait_fs("drain_sync", 400, n);
    step(50);
    ene = 1'b0;
    step(200);
    chk("drain_idle", {30'd0, busy, de}, 0);

    ene = 1'b1;
    wait_fs("reen_sync", 400, n);
    step(50);
    ene = 1'b0;
    step(50);
    ene = 1'b1;
    step(300);
    chk("reen_busy", 32'(busy), 1);

    wait_fs("col_sync", 400, n);
    step(30);
    color = 24'hABCDEF;
    wait_fs("col_next", 400, n);
    chk("col_delay", 32'(n), FP - 30);
    chk("col_new", 32'(pixel_rgb), 32'hABCDEF);

    step(10);
    rst = 1'b0;
    #1;
    chk("rst_async_rgb", 32'(pixel_rgb), 0);
    chk("rst_async_flags", {27'd0, de, hsync, vsync, frame_start, busy}, 0);
    step(2);
    rst = 1'b1;
    wait_fs("rst_restart", 400, n);
    chk("rst_restart_n", 32'(n), 2);
    chk("rst_restart_rgb", 32'(pixel_rgb), 32'hABCDEF);

    pattern_sel = 1'b1;
    wait_fs("bar_sync", 400, n);
`ifdef LVDS_COLORBAR_EN
    chk("bar_0", 32'(pixel_rgb), 32'hFFFFFF);
    step(2);
    chk("bar_2", 32'(pixel_rgb), 32'hFFFF00);
    step(2);
    chk("bar_4", 32'(pixel_rgb), 32'h00FFFF);
    step(10);
    chk("bar_14", 32'(pixel_rgb), 32'h000000);
    step(1);
    chk("bar_15_de", 32'(de), 1);
`else
    chk("nobar_0", 32'(pixel_rgb), 32'hABCDEF);
    step(14);
    chk("nobar_14", 32'(pixel_rgb), 32'hABCDEF);
    step(1);
    chk("nobar_15_de", 32'(de), 1);
`endif
    step(1);
    chk("bar_16_blank", {7'd0, pixel_rgb, de}, 0);

    ce_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) ene = ~ene;
      if ($urandom_range(0, 39) == 0) color = 24'($urandom);
      if ($urandom_range(0, 99) == 0) pattern_sel = ~pattern_sel;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        step(1);
        rst = 1'b1;
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
